// File: rtl/debouncer_bank.sv
// debouncer_bank: WIDTH independent debounce channels sharing one clock-enable tick.
// Each channel has an optional synchroniser, an IDLE/CHANGING glitch filter and registered rise/fall strobes.
module debouncer_bank #(
    parameter int unsigned      WIDTH        = 8,
    parameter int unsigned      NOISE_PERIOD = 256,
    parameter logic [WIDTH-1:0] RESET_VALUE  = {WIDTH{1'b0}},
    parameter int unsigned      SYNC_STAGES  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] busy_o
);

    localparam int unsigned      CNT_W   = $clog2(NOISE_PERIOD);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NOISE_PERIOD - 1);

    typedef enum logic {
        IDLE     = 1'b0,
        CHANGING = 1'b1
    } state_e;

    logic [WIDTH-1:0] sync_s;

    // Synchroniser runs every clock; enable only gates the filter behind it.
    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [WIDTH-1:0] sync_q [SYNC_STAGES];
            logic [WIDTH-1:0] sync_d [SYNC_STAGES];

            always_comb begin
                sync_d[0] = data_i;
                for (int k = 1; k < SYNC_STAGES; k++) begin
                    sync_d[k] = sync_q[k-1];
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= RESET_VALUE;
                    end
                end else begin
                    for (int k = 0; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_d[k];
                    end
                end
            end

            assign sync_s = sync_q[SYNC_STAGES-1];
        end else begin : g_nosync
            assign sync_s = data_i;
        end
    endgenerate

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            state_e           state_q, state_d;
            logic [CNT_W-1:0] count_q, count_d;
            logic             data_q, data_d;
            logic             rise_q, rise_d;
            logic             fall_q, fall_d;

            // Strobes default low so they last exactly one clock even with enable low.
            always_comb begin
                state_d = state_q;
                count_d = count_q;
                data_d  = data_q;
                rise_d  = 1'b0;
                fall_d  = 1'b0;
                if (enable) begin
                    case (state_q)
                        IDLE: begin
                            if (sync_s[i] != data_q) begin
                                state_d = CHANGING;
                                count_d = '0;
                            end
                        end
                        CHANGING: begin
                            if (sync_s[i] == data_q) begin
                                state_d = IDLE;
                                count_d = '0;
                            end else if (count_q == CNT_MAX) begin
                                state_d = IDLE;
                                count_d = '0;
                                data_d  = sync_s[i];
                                rise_d  = sync_s[i];
                                fall_d  = ~sync_s[i];
                            end else begin
                                count_d = count_q + 1'b1;
                            end
                        end
                        default: begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    state_q <= IDLE;
                    count_q <= '0;
                    data_q  <= RESET_VALUE[i];
                    rise_q  <= 1'b0;
                    fall_q  <= 1'b0;
                end else begin
                    state_q <= state_d;
                    count_q <= count_d;
                    data_q  <= data_d;
                    rise_q  <= rise_d;
                    fall_q  <= fall_d;
                end
            end

            assign data_o[i] = data_q;
            assign rise_o[i] = rise_q;
            assign fall_o[i] = fall_q;
            assign busy_o[i] = (state_q == CHANGING);
        end
    endgenerate

endmodule
